// File: rtl/ysyx_2022040010_uncache_wr_if.sv
// rtl/ysyx_2022040010_uncache_wr_if.sv - LSU request plus AXI4 write-channel bundle for the uncached store path
//
// Purpose: groups the LSU store request, the single-beat AXI4 AW/W/B channels
//          and the done/err completion status into one interface.
// Modports:
//   master : the uncached write block (accepts LSU requests, drives AW/W, consumes B)
//   slave  : the environment (LSU request source plus AXI slave / interconnect)
// Signals:
//   req_valid/req_ready/req_addr/req_size/req_wdata/req_wstrb : LSU store request
//   awvalid/awready/awaddr/awsize/awid/awlen/awburst          : AXI write address
//   wvalid/wready/wdata/wstrb/wlast                           : AXI write data
//   bvalid/bready/bresp                                       : AXI write response
//   done/err                                                  : completion pulse and error flag
interface ysyx_2022040010_uncache_wr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [2:0]            req_size;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awsize;
  logic [3:0]            awid;
  logic [7:0]            awlen;
  logic [1:0]            awburst;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  done;
  logic                  err;

  modport master (
    input  req_valid, req_addr, req_size, req_wdata, req_wstrb,
    output req_ready,
    output awvalid, awaddr, awsize, awid, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output done, err
  );

  modport slave (
    output req_valid, req_addr, req_size, req_wdata, req_wstrb,
    input  req_ready,
    input  awvalid, awaddr, awsize, awid, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  done, err
  );
endinterface

// File: rtl/ysyx_2022040010_uncache_wr.sv
// rtl/ysyx_2022040010_uncache_wr.sv - single-beat AXI4 write engine for uncached (MMIO) stores
//
// Purpose: captures one uncached store from the LSU, issues it as a single-beat
//          AXI4 write (AW + W, then B) and reports completion with a one-cycle
//          done pulse plus err (bresp != OKAY). The LSU is held off through
//          req_ready until the response has been consumed.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ysyx_2022040010_uncache_wr_if.master (LSU request, AW/W/B, done/err)
module ysyx_2022040010_uncache_wr #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_2022040010_uncache_wr_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic              aw_ok;
  logic              w_ok;
  logic              err_q;

  logic req_ready_c;
  logic awvalid_c;
  logic wvalid_c;
  logic bready_c;
  logic done_c;

  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    awvalid_c   = 1'b0;
    wvalid_c    = 1'b0;
    bready_c    = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_next = SEND;
      end
      SEND: begin
        // Each channel stays valid until its own handshake has been recorded.
        awvalid_c = ~aw_ok;
        wvalid_c  = ~w_ok;
        // While a flag is clear its valid is high, so "flag or ready" is the
        // same as "flag or handshake this cycle".
        if ((aw_ok | bus.awready) & (w_ok | bus.wready)) state_next = WAIT_B;
      end
      WAIT_B: begin
        bready_c = 1'b1;
        if (bus.bvalid) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        size_q <= bus.req_size;
        data_q <= bus.req_wdata;
        strb_q <= bus.req_wstrb;
        aw_ok  <= 1'b0;
        w_ok   <= 1'b0;
      end
      if (state == SEND) begin
        if (bus.awvalid && bus.awready) aw_ok <= 1'b1;
        if (bus.wvalid && bus.wready)   w_ok  <= 1'b1;
      end
      if (state == WAIT_B && bus.bvalid) err_q <= |bus.bresp;
    end
  end

  assign bus.req_ready = req_ready_c;

  assign bus.awvalid = awvalid_c;
  assign bus.awaddr  = addr_q;
  assign bus.awsize  = size_q;
  assign bus.awid    = AXI_ID;
  assign bus.awlen   = 8'd0;
  assign bus.awburst = 2'b01;

  assign bus.wvalid  = wvalid_c;
  assign bus.wdata   = data_q;
  assign bus.wstrb   = strb_q;
  assign bus.wlast   = wvalid_c;

  assign bus.bready  = bready_c;

  assign bus.done    = done_c;
  assign bus.err     = done_c & err_q;
endmodule

// File: tb/tb_ysyx_2022040010_uncache_wr.sv
// tb/tb_ysyx_2022040010_uncache_wr.sv - randomized scoreboard bench for the uncached write engine
module tb_ysyx_2022040010_uncache_wr;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_2022040010_uncache_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ysyx_2022040010_uncache_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
  } req_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  req_t exp_q[$];
  bit   exp_err_q[$];
  int   acc_hist[$];

  // slave configuration for the current transaction
  int       aw_delay = 0;
  int       w_delay = 0;
  int       b_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit       slave_en = 1'b1;

  // reference-model bookkeeping
  int   outstanding = 0;
  int   acc_cyc = 0;
  int   exp_lat = -1;
  bit   aw_seen = 1'b0;
  bit   w_seen = 1'b0;
  int   aw_hi = 0;
  int   w_hi = 0;
  logic [31:0] last_awaddr = '0;
  logic [63:0] last_wdata = '0;
  int   done_cnt = 0;
  int   aw_total = 0;
  int   w_total = 0;
  int   done_total = 0;

  bit aw_hs_s = 1'b0;
  bit w_hs_s = 1'b0;
  bit b_hs_s = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all DUT outputs are sampled on the falling edge, where they hold
  // the values the next rising edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      aw_hs_s = 1'b0;
      w_hs_s  = 1'b0;
      b_hs_s  = 1'b0;
    end else begin
      chk("req_ready", 64'(bus.req_ready), 64'(outstanding == 0));
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back('{addr: bus.req_addr, size: bus.req_size,
                          data: bus.req_wdata, strb: bus.req_wstrb});
        outstanding++;
        acc_cyc = cyc;
        acc_hist.push_back(cyc);
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        aw_hi   = 0;
        w_hi    = 0;
      end
      chk("wlast_eq_wvalid", 64'(bus.wlast), 64'(bus.wvalid));
      if (bus.awvalid) begin
        chk("awvalid_after_hs", 64'(aw_seen), 64'd0);
        if (aw_hi > 0) chk("awaddr_stable", 64'(bus.awaddr), 64'(last_awaddr));
        aw_hi++;
        last_awaddr = bus.awaddr;
        if (bus.awready) begin
          aw_seen = 1'b1;
          aw_total++;
          chk("aw_hold_cycles", 64'(aw_hi), 64'(aw_delay + 1));
          if (exp_q.size() == 0) begin
            chk("aw_unexpected", 64'd1, 64'd0);
          end else begin
            chk("awaddr", 64'(bus.awaddr), 64'(exp_q[0].addr));
            chk("awsize", 64'(bus.awsize), 64'(exp_q[0].size));
            chk("awid_len_burst", {52'd0, bus.awid, bus.awlen}, {52'd0, 4'd0, 8'd0});
            chk("awburst", 64'(bus.awburst), 64'd1);
          end
        end
      end
      if (bus.wvalid) begin
        chk("wvalid_after_hs", 64'(w_seen), 64'd0);
        if (w_hi > 0) chk("wdata_stable", bus.wdata, last_wdata);
        w_hi++;
        last_wdata = bus.wdata;
        if (bus.wready) begin
          w_seen = 1'b1;
          w_total++;
          chk("w_hold_cycles", 64'(w_hi), 64'(w_delay + 1));
          if (exp_q.size() == 0) begin
            chk("w_unexpected", 64'd1, 64'd0);
          end else begin
            chk("wdata", bus.wdata, exp_q[0].data);
            chk("wstrb", 64'(bus.wstrb), 64'(exp_q[0].strb));
          end
        end
      end
      if (bus.bready) chk("bready_before_aw_w", 64'(aw_seen && w_seen), 64'd1);
      if (bus.done) begin
        if (exp_q.size() == 0 || exp_err_q.size() == 0) begin
          chk("done_unexpected", 64'd1, 64'd0);
        end else begin
          void'(exp_q.pop_front());
          chk("err", 64'(bus.err), 64'(exp_err_q.pop_front()));
          if (exp_lat >= 0) chk("done_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        end
        if (outstanding > 0) outstanding--;
        done_cnt++;
        done_total++;
      end else begin
        chk("err_without_done", 64'(bus.err), 64'd0);
      end
      aw_hs_s = bus.awvalid && bus.awready;
      w_hs_s  = bus.wvalid && bus.wready;
      b_hs_s  = bus.bvalid && bus.bready;
    end
  end

  // AXI slave model: drives ready/response just after each rising edge.
  initial begin
    int  aw_cnt = 0;
    int  w_cnt = 0;
    int  b_cnt = 0;
    bit  aw_got = 1'b0;
    bit  w_got = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !slave_en) begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        if (rst) bus.bvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (aw_hs_s) begin aw_got = 1'b1; aw_cnt = 0; end
        if (w_hs_s)  begin w_got = 1'b1;  w_cnt = 0;  end
        if (b_hs_s) begin
          bus.bvalid = 1'b0;
          aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
        end
        if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else bus.awready = 1'b0;
        if (bus.wvalid) begin bus.wready = (w_cnt >= w_delay); w_cnt++; end
        else bus.wready = 1'b0;
        if (aw_got && w_got && !bus.bvalid) begin
          if (b_cnt >= b_delay) begin
            bus.bvalid = 1'b1;
            bus.bresp  = bresp_cfg;
            exp_err_q.push_back(bresp_cfg != 2'b00);
          end else begin
            b_cnt++;
          end
        end
      end
    end
  end

  task automatic set_slave(input int awd, input int wd, input int bd, input logic [1:0] br);
    aw_delay  = awd;
    w_delay   = wd;
    b_delay   = bd;
    bresp_cfg = br;
    exp_lat   = ((awd > wd) ? awd : wd) + bd + 3;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [2:0] s,
                        input logic [63:0] d, input logic [7:0] st);
    int start = done_cnt;
    int n = 0;
    @(posedge clk);
    #1;
    bus.req_addr  = a;
    bus.req_size  = s;
    bus.req_wdata = d;
    bus.req_wstrb = st;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done(start);
  endtask

  initial begin
    int start;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    #1;
    chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
    chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
    chk("rst_bready", 64'(bus.bready), 64'd0);
    chk("rst_done_err", 64'({bus.done, bus.err}), 64'd0);
    chk("rst_awaddr", 64'(bus.awaddr), 64'd0);
    chk("rst_wdata", bus.wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 64'(bus.req_ready), 64'd1);

    // zero-wait MMIO byte store
    set_slave(0, 0, 0, 2'b00);
    do_req(32'ha000_03f8, 3'd0, 64'h41, 8'h01);
    // AW delayed, W immediate
    set_slave(3, 0, 0, 2'b00);
    do_req(32'h1000_0010, 3'd3, 64'hdead_beef_0123_4567, 8'hff);
    // W delayed, AW immediate
    set_slave(0, 5, 0, 2'b00);
    do_req(32'h1000_0020, 3'd2, 64'h0000_0000_cafe_f00d, 8'h0f);
    // SLVERR then OKAY
    set_slave(0, 0, 1, 2'b10);
    do_req(32'h1000_0030, 3'd1, 64'h0000_0000_0000_5a5a, 8'h03);
    set_slave(0, 0, 0, 2'b00);
    do_req(32'h1000_0040, 3'd1, 64'h0000_0000_0000_a5a5, 8'h0c);

    // req_valid held high across the transaction, payload swapped after accept
    set_slave(0, 0, 0, 2'b00);
    start = done_cnt;
    acc_hist.delete();
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h2000_0008;
    bus.req_size  = 3'd3;
    bus.req_wdata = 64'h1111_2222_3333_4444;
    bus.req_wstrb = 8'hff;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h2000_0010;
    bus.req_wdata = 64'h5555_6666_7777_8888;
    bus.req_wstrb = 8'hf0;
    wait_done(start);
    start = done_cnt;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done(start);
    chk("held_valid_accepts", 64'(acc_hist.size()), 64'd2);
    if (acc_hist.size() == 2) chk("reaccept_gap", 64'(acc_hist[1] - acc_hist[0]), 64'd4);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int r = $urandom_range(0, 3);
      set_slave($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                (r == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      do_req($urandom, 3'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom));
    end

    // reset while SEND with awvalid high
    set_slave(10, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h3000_0000;
    bus.req_wdata = 64'h77;
    bus.req_wstrb = 8'h01;
    bus.req_size  = 3'd0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_awvalid", 64'(bus.awvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_awvalid", 64'(bus.awvalid), 64'd0);
    chk("async_rst_wvalid", 64'(bus.wvalid), 64'd0);
    chk("async_rst_bready", 64'(bus.bready), 64'd0);
    exp_q.delete();
    exp_err_q.delete();
    outstanding = 0;
    aw_total = 0; w_total = 0; done_total = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    slave_en = 1'b0;
    @(negedge clk);
    chk("req_ready_after_mid_rst", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("stray_b_bready", 64'(bus.bready), 64'd0);
      chk("stray_b_done", 64'(bus.done), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.bvalid = 1'b0;
    slave_en = 1'b1;
    set_slave(0, 0, 0, 2'b00);
    do_req(32'h3000_0100, 3'd3, 64'h0123_4567_89ab_cdef, 8'hff);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("aw_count", 64'(aw_total), 64'(done_total));
    chk("w_count", 64'(w_total), 64'(done_total));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
